// File: rtl/ctrl_exposure_autorepeat_if.sv
// Button/lock inputs and exposure-value outputs of the exposure auto-repeat controller.
interface ctrl_exposure_autorepeat_if #(
  parameter int unsigned W = 5
) ();
  logic         exp_inc;
  logic         exp_dec;
  logic         lock;
  logic [W-1:0] ex_time;
  logic         at_min;
  logic         at_max;
  logic         changed;

  modport master (
    output exp_inc, exp_dec, lock,
    input  ex_time, at_min, at_max, changed
  );

  modport slave (
    input  exp_inc, exp_dec, lock,
    output ex_time, at_min, at_max, changed
  );
endinterface

// File: rtl/ctrl_exposure_autorepeat.sv
// Exposure-time controller: synchronised, debounced inc/dec buttons with hold-to-repeat,
// saturating between MIN_T and MAX_T, frozen while lock is high.
module ctrl_exposure_autorepeat #(
  parameter int unsigned W             = 5,
  parameter int unsigned MIN_T         = 2,
  parameter int unsigned MAX_T         = 30,
  parameter int unsigned INIT_T        = 15,
  parameter int unsigned STEP          = 1,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  ctrl_exposure_autorepeat_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StQual, StHold, StRpt} state_e;
  typedef enum logic [1:0] {DirNone, DirInc, DirDec} dir_e;

  localparam logic [W-1:0]     MinT    = W'(MIN_T);
  localparam logic [W-1:0]     MaxT    = W'(MAX_T);
  localparam logic [W-1:0]     InitT   = W'(INIT_T);
  localparam logic [W-1:0]     StepT   = W'(STEP);
  localparam logic [W:0]       MinW    = (W+1)'(MIN_T);
  localparam logic [W:0]       MaxW    = (W+1)'(MAX_T);
  localparam logic [W:0]       StepW   = (W+1)'(STEP);
  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DlyLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PerLast = CNT_W'(REPEAT_PERIOD - 1);

  logic             r_inc_s1, r_inc_s2, r_dec_s1, r_dec_s2;
  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_timer, w_timer_d;
  dir_e             r_dir, w_dir_d, w_dir;
  logic             w_step, w_apply;
  logic [W:0]       w_sum;
  logic [W-1:0]     w_next;
  logic [W-1:0]     r_ex_time;
  logic             r_at_min, r_at_max, r_changed;

  // Two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inc_s1 <= 1'b0;
      r_inc_s2 <= 1'b0;
      r_dec_s1 <= 1'b0;
      r_dec_s2 <= 1'b0;
    end else begin
      r_inc_s1 <= bus.exp_inc;
      r_inc_s2 <= r_inc_s1;
      r_dec_s1 <= bus.exp_dec;
      r_dec_s2 <= r_dec_s1;
    end
  end

  always_comb begin
    w_dir = DirNone;
    if (r_inc_s2 && !r_dec_s2)      w_dir = DirInc;
    else if (r_dec_s2 && !r_inc_s2) w_dir = DirDec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_dir   <= DirNone;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_dir   <= w_dir_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_dir_d   = r_dir;
    w_step    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_dir != DirNone) begin
          w_state_d = StQual;
          w_timer_d = '0;
          w_dir_d   = w_dir;
        end
      end
      StQual: begin
        if (w_dir != r_dir) begin
          w_state_d = StIdle;
          w_timer_d = '0;
        end else if (r_timer == DebLast) begin
          w_step    = 1'b1;
          w_state_d = StHold;
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer + CNT_W'(1);
        end
      end
      StHold: begin
        if (w_dir != r_dir) begin
          w_state_d = StIdle;
          w_timer_d = '0;
        end else if (r_timer == DlyLast) begin
          w_step    = 1'b1;
          w_state_d = StRpt;
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer + CNT_W'(1);
        end
      end
      StRpt: begin
        if (w_dir != r_dir) begin
          w_state_d = StIdle;
          w_timer_d = '0;
        end else if (r_timer == PerLast) begin
          w_step    = 1'b1;
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer + CNT_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_timer_d = '0;
      end
    endcase
  end

  // Saturating step in W+1 bits so the sum can never wrap
  always_comb begin
    w_sum  = {1'b0, r_ex_time} + StepW;
    w_next = r_ex_time;
    if (r_dir == DirInc) begin
      w_next = (w_sum > MaxW) ? MaxT : w_sum[W-1:0];
    end else if (r_dir == DirDec) begin
      w_next = ({1'b0, r_ex_time} < (MinW + StepW)) ? MinT : (r_ex_time - StepT);
    end
  end

  // Lock only drops the value update; the FSM schedule is unaffected
  assign w_apply = w_step && !bus.lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_time <= InitT;
      r_at_min  <= (INIT_T == MIN_T);
      r_at_max  <= (INIT_T == MAX_T);
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_apply && (w_next != r_ex_time);
      if (w_apply) begin
        r_ex_time <= w_next;
        r_at_min  <= (w_next == MinT);
        r_at_max  <= (w_next == MaxT);
      end
    end
  end

  assign bus.ex_time = r_ex_time;
  assign bus.at_min  = r_at_min;
  assign bus.at_max  = r_at_max;
  assign bus.changed = r_changed;

endmodule
